// File: rtl/counter_8b.sv
// counter_8b: WIDTH-bit synchronous up-counter built from a rippled chain of toggle stages.
// Latency: one clk edge from T sampled high to the increment on Q; clr clears on the next edge.
// Backpressure: none; T is a plain count enable and the counter never stalls its source.
//
// Ports:
//   T   in   1      count enable (toggle enable of stage 0), active-high
//   clk in   1      rising-edge clock
//   clr in   1      synchronous active-high clear; overrides T
//   Q   out  WIDTH  current count, straight from the stage flops
//   tc  out  1      terminal count (only when COUNTER_8B_TC_EN is defined):
//                   high when Q is all ones, T = 1 and clr = 0, so the next
//                   edge wraps; usable as the T of a following cascaded counter
//
// Build option: define COUNTER_8B_TC_EN to add the tc output.

module counter_8b #(
  parameter int WIDTH = 8
) (
  input  logic             T,
  input  logic             clk,
  input  logic             clr,
`ifdef COUNTER_8B_TC_EN
  output logic [WIDTH-1:0] Q,
  output logic             tc
`else
  output logic [WIDTH-1:0] Q
`endif
);

  // Stage flops and their next state.
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Per-stage toggle enable. Stage i toggles only when every lower stage is 1
  // and counting is enabled, which yields binary increment without an adder.
  logic [WIDTH-1:0] tog_en;

  // Rippled AND chain: each stage's enable is built from the one below it.
  always_comb begin
    tog_en[0] = T;
    for (int i = 1; i < WIDTH; i++) begin
      tog_en[i] = tog_en[i-1] & q_q[i-1];
    end
  end

  // A T stage flips when its enable is high and holds otherwise.
  always_comb begin
    q_d = q_q ^ tog_en;
  end

  // Clear has priority over counting, so clr at all-ones gives 0 and no wrap artefact.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

`ifdef COUNTER_8B_TC_EN
  // The top stage's enable ANDed with its own bit is exactly "all ones and T".
  // Gating with clr keeps tc low on an edge that will clear instead of wrap.
  assign tc = tog_en[WIDTH-1] & q_q[WIDTH-1] & ~clr;
`endif

endmodule

// File: tb/tb_counter_8b.sv
// tb_counter_8b: directed self-checking bench for counter_8b (WIDTH = 8).
// Latency: drives inputs 1 time unit after each rising edge and checks 1 unit after the next one.
// Backpressure: none; every edge is checked against a hand-computed expected count.

module tb_counter_8b;

  logic       clk;
  logic       T;
  logic       clr;
  logic [7:0] Q;
`ifdef COUNTER_8B_TC_EN
  logic       tc;
`endif

  int n_tests;
  int n_fail;

  counter_8b #(.WIDTH(8)) dut (
    .T   (T),
    .clk (clk),
    .clr (clr),
`ifdef COUNTER_8B_TC_EN
    .Q   (Q),
    .tc  (tc)
`else
    .Q   (Q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance n edges with the current inputs, no checks.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    T   = 1'b1;
    clr = 1'b1;

    // Reset: clr with T = 1 for two edges, Q = 0 after each.
    step(); check_eq("reset_edge1", Q, 8'h00);
    step(); check_eq("reset_edge2", Q, 8'h00);

    // Count 1..16.
    clr = 1'b0; T = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check_eq($sformatf("count_%0d", i), Q, 8'(i));
    end

    // Hold at 5: clear, count to 5, then T = 0 for 4 edges.
    clr = 1'b1; step(); clr = 1'b0;
    run(5);
    check_eq("hold_start", Q, 8'h05);
    T = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("hold_%0d", i), Q, 8'h05);
    end
    T = 1'b1; step(); check_eq("hold_resume", Q, 8'h06);

    // Wrap: 6 -> FF takes 249 edges, then FF -> 00.
    run(249);
    check_eq("wrap_ff", Q, 8'hFF);
`ifdef COUNTER_8B_TC_EN
    check_eq("tc_ff_t1", {7'b0, tc}, 8'h01);
    T = 1'b0; #1;
    check_eq("tc_ff_t0", {7'b0, tc}, 8'h00);
    clr = 1'b1; #1;
    check_eq("tc_ff_clr", {7'b0, tc}, 8'h00);
    clr = 1'b0; T = 1'b1; #1;
`endif
    step(); check_eq("wrap_00", Q, 8'h00);
`ifdef COUNTER_8B_TC_EN
    check_eq("tc_00", {7'b0, tc}, 8'h00);
`endif

    // Clear priority at 7F: 0 -> 7F is 127 edges.
    run(127);
    check_eq("prio_7f", Q, 8'h7F);
    clr = 1'b1; T = 1'b1; step(); check_eq("prio_clr", Q, 8'h00);
    clr = 1'b0;           step(); check_eq("prio_after", Q, 8'h01);

    // Carry ripple: 1 -> 0F (14), -> 10; 10 -> 3F (47), -> 40; 40 -> 7F (63), -> 80.
    run(14); check_eq("rip_0f", Q, 8'h0F);
    step();  check_eq("rip_10", Q, 8'h10);
    run(47); check_eq("rip_3f", Q, 8'h3F);
    step();  check_eq("rip_40", Q, 8'h40);
    run(63); check_eq("rip_7f", Q, 8'h7F);
    step();  check_eq("rip_80", Q, 8'h80);

    // Clear mid-count at FF: 80 -> FF is 127 edges, then clr.
    run(127); check_eq("clrff_pre", Q, 8'hFF);
    clr = 1'b1; step(); check_eq("clrff_post", Q, 8'h00);

    // Clear held 3 edges with T = 0, then resume counting.
    T = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("clr_hold_%0d", i), Q, 8'h00);
    end
    clr = 1'b0; T = 1'b1; step(); check_eq("clr_resume", Q, 8'h01);

    // T toggled every cycle: pattern 0,1,0,1,1,0,1,0 from 1 -> 2,2? hand values below.
    begin
      logic [7:0] tpat;
      logic [7:0] exp_seq [8];
      tpat = 8'b0101_1010; // applied LSB first: 0,1,0,1,1,0,1,0
      exp_seq = '{8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
      for (int i = 0; i < 8; i++) begin
        T = tpat[i];
        step();
        check_eq($sformatf("toggle_%0d", i), Q, exp_seq[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
